// File: rtl/mult_share_pkg.sv
// Shared constants and helpers for the multiplier-sharing arbiter and its core.
package mult_share_pkg;

  localparam int MULT_W   = 4;
  localparam int MULT_P_W = 2 * MULT_W;

  // Round-robin successor with an explicit wrap, so n need not be a power of two.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/multiplier_4bit.sv
// Combinational 4x4 unsigned multiplier core with a full 8-bit product.
module multiplier_4bit
  import mult_share_pkg::*;
(
  input  logic [MULT_W-1:0]   a,
  input  logic [MULT_W-1:0]   b,
  output logic [MULT_P_W-1:0] p
);

  assign p = MULT_P_W'(a) * MULT_P_W'(b);

endmodule

// File: rtl/rr_arbiter.sv
// Purely combinational round-robin arbiter: scans from ptr upward with wrap and
// grants the first requester found, only while enable is high.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             enable,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_any
);

  int scan_idx;

  always_comb begin
    gnt      = '0;
    gnt_idx  = '0;
    gnt_any  = 1'b0;
    scan_idx = 0;
    if (enable) begin
      for (int k = 0; k < N; k++) begin
        scan_idx = int'(ptr) + k;
        if (scan_idx >= N) scan_idx = scan_idx - N;
        if (!gnt_any && req[IDX_W'(scan_idx)]) begin
          gnt[IDX_W'(scan_idx)] = 1'b1;
          gnt_idx               = IDX_W'(scan_idx);
          gnt_any               = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one W x W unsigned multiplier among N_REQ valid/ready requesters with
// round-robin arbitration and a single-entry, backpressured result register.
module mult_share_arbiter
  import mult_share_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W     = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [2*W-1:0]     res_p,
  output logic [ID_W-1:0]    res_id
);

  logic             res_valid_q, res_valid_d;
  logic [2*W-1:0]   res_p_q, res_p_d;
  logic [ID_W-1:0]  res_id_q, res_id_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;

  logic             free;
  logic             arb_en;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_idx;
  logic             gnt_any;
  logic [W-1:0]     op_a, op_b;
  logic [2*W-1:0]   prod;

  // Gating with rst_n keeps req_ready low for the whole reset, not just after it.
  assign free   = !res_valid_q || res_ready;
  assign arb_en = rst_n && free;

  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (ID_W)
  ) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .enable  (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign req_ready = gnt;

  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_idx == ID_W'(i)) begin
        op_a = req_a[i*W +: W];
        op_b = req_b[i*W +: W];
      end
    end
  end

  generate
    if (W == MULT_W) begin : g_core4
      multiplier_4bit u_core (
        .a (op_a),
        .b (op_b),
        .p (prod)
      );
    end else begin : g_core_generic
      assign prod = (2*W)'(op_a) * (2*W)'(op_b);
    end
  endgenerate

  // An accept always wins over a plain drain, which gives back-to-back results.
  always_comb begin
    res_valid_d = res_valid_q;
    res_p_d     = res_p_q;
    res_id_d    = res_id_q;
    rr_ptr_d    = rr_ptr_q;
    if (gnt_any) begin
      res_valid_d = 1'b1;
      res_p_d     = prod;
      res_id_d    = gnt_idx;
      rr_ptr_d    = ID_W'(rr_next(int'(gnt_idx), N_REQ));
    end else if (res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      res_p_q     <= '0;
      res_id_q    <= '0;
      rr_ptr_q    <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      res_p_q     <= res_p_d;
      res_id_q    <= res_id_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_p     = res_p_q;
  assign res_id    = res_id_q;

endmodule
